torque_ramp_controller: RTL and testbench

- Upstream driver for the torque_display stage. Accepts drive commands (direction plus target torque level) through a valid/ready handshake.
- Produces `enable`, `instruction[1:0]` and `torque[1:0]`, which connect directly to torque_display.
- Moves torque toward the target one level per step period, so the LED bar graph ramps rather than jumps.
- A direction change always ramps torque to 0 before `instruction` switches.

---
 rtl/torque_pkg.sv | 34 +++
 rtl/step_timer.sv | 29 ++
 rtl/torque_ramp_controller.sv | 160 ++++++++++++++++
 tb/tb_torque_ramp_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/torque_pkg.sv
// Shared types and helpers for the torque drive path.
package torque_pkg;

  localparam int unsigned TORQUE_W = 2;

  typedef logic [TORQUE_W-1:0] torque_t;

  localparam torque_t TORQUE_MAX = 2'd3;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'd0,
    DIR_REV   = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } ctrl_state_t;

  // Saturating one-level increment; never wraps past TORQUE_MAX.
  function automatic torque_t tq_inc(input torque_t t);
    return (t == TORQUE_MAX) ? t : torque_t'(t + torque_t'(1));
  endfunction

  // Saturating one-level decrement; never wraps below zero.
  function automatic torque_t tq_dec(input torque_t t);
    return (t == torque_t'(0)) ? t : torque_t'(t - torque_t'(1));
  endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running pacing timer: pulses step on the last cycle of each period.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic step
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign step = (count == TERMINAL);

  // Count 0..STEP_CYCLES-1 and wrap; clear restarts the period from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || step) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/torque_ramp_controller.sv
// Command-driven torque ramp controller feeding torque_display.
module torque_ramp_controller
  import torque_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dir,
  input  logic [1:0] cmd_torque,
  input  logic       estop,
  output logic       busy,
  output logic       enable,
  output logic [1:0] instruction,
  output logic [1:0] torque
);

  ctrl_state_t state;
  dir_t        tgt_dir;
  torque_t     tgt_tq;
  logic        pending_switch;
  logic        step;
  logic        accept_c;
  logic        clear_c;
  torque_t     tq_up_c;
  torque_t     tq_dn_c;
  torque_t     floor_c;

  assign cmd_ready = ((state == ST_IDLE) || (state == ST_HOLD)) && !estop;
  assign accept_c  = cmd_valid && cmd_ready;

  // Next torque candidates and the ramp-down stopping level.
  always_comb begin
    tq_up_c = tq_inc(torque);
    tq_dn_c = tq_dec(torque);
    floor_c = pending_switch ? torque_t'(0) : tgt_tq;
  end

  // Restart the step period whenever an accepted command starts a ramp.
  always_comb begin
    clear_c = 1'b0;
    if (accept_c && (state == ST_IDLE) && (cmd_torque != 2'd0)) begin
      clear_c = 1'b1;
    end
    if (accept_c && (state == ST_HOLD) &&
        ((cmd_dir != instruction) || (cmd_torque != torque))) begin
      clear_c = 1'b1;
    end
  end

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clear_c),
    .step (step)
  );

  // Controller FSM with registered outputs; estop overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      tgt_dir        <= DIR_FWD;
      tgt_tq         <= '0;
      pending_switch <= 1'b0;
      enable         <= 1'b0;
      instruction    <= DIR_FWD;
      torque         <= '0;
      busy           <= 1'b0;
    end else if (estop) begin
      state          <= ST_IDLE;
      tgt_dir        <= DIR_FWD;
      tgt_tq         <= '0;
      pending_switch <= 1'b0;
      enable         <= 1'b0;
      torque         <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            tgt_dir     <= dir_t'(cmd_dir);
            tgt_tq      <= cmd_torque;
            instruction <= cmd_dir;
            if (cmd_torque != 2'd0) begin
              enable <= 1'b1;
              busy   <= 1'b1;
              state  <= ST_RAMP_UP;
            end
          end
        end

        ST_HOLD: begin
          if (accept_c) begin
            if (cmd_dir != instruction) begin
              tgt_dir        <= dir_t'(cmd_dir);
              tgt_tq         <= cmd_torque;
              pending_switch <= 1'b1;
              busy           <= 1'b1;
              state          <= ST_RAMP_DOWN;
            end else if (cmd_torque > torque) begin
              tgt_tq <= cmd_torque;
              busy   <= 1'b1;
              state  <= ST_RAMP_UP;
            end else if (cmd_torque < torque) begin
              tgt_tq <= cmd_torque;
              busy   <= 1'b1;
              state  <= ST_RAMP_DOWN;
            end
          end
        end

        ST_RAMP_UP: begin
          if (step) begin
            torque <= tq_up_c;
            if ((tq_up_c >= tgt_tq) || (torque == TORQUE_MAX)) begin
              busy  <= 1'b0;
              state <= ST_HOLD;
            end
          end
        end

        ST_RAMP_DOWN: begin
          if (step) begin
            torque <= tq_dn_c;
            if (tq_dn_c <= floor_c) begin
              if (pending_switch) begin
                instruction    <= tgt_dir;
                pending_switch <= 1'b0;
                if (tgt_tq != torque_t'(0)) begin
                  state <= ST_RAMP_UP;
                end else begin
                  enable <= 1'b0;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
                end
              end else if (tgt_tq != torque_t'(0)) begin
                busy  <= 1'b0;
                state <= ST_HOLD;
              end else begin
                enable <= 1'b0;
                busy   <= 1'b0;
                state  <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_torque_ramp_controller.sv
// Directed bench for torque_ramp_controller with STEP_CYCLES=4.
module tb_torque_ramp_controller;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dir;
  logic [1:0] cmd_torque;
  logic       estop;
  logic       busy;
  logic       enable;
  logic [1:0] instruction;
  logic [1:0] torque;

  int checks;
  int failures;

  torque_ramp_controller #(
    .STEP_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_torque (cmd_torque),
    .estop      (estop),
    .busy       (busy),
    .enable     (enable),
    .instruction(instruction),
    .torque     (torque)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare all five observable outputs against expected values.
  task automatic expect_outs(input string tag, input logic en_e, input logic [1:0] ins_e,
                             input logic [1:0] tq_e, input logic busy_e, input logic rdy_e);
    checks++;
    assert (enable === en_e) else begin
      failures++;
      $error("FAIL %s.enable observed=%0b expected=%0b", tag, enable, en_e);
    end
    checks++;
    assert (instruction === ins_e) else begin
      failures++;
      $error("FAIL %s.instruction observed=%0d expected=%0d", tag, instruction, ins_e);
    end
    checks++;
    assert (torque === tq_e) else begin
      failures++;
      $error("FAIL %s.torque observed=%0d expected=%0d", tag, torque, tq_e);
    end
    checks++;
    assert (busy === busy_e) else begin
      failures++;
      $error("FAIL %s.busy observed=%0b expected=%0b", tag, busy, busy_e);
    end
    checks++;
    assert (cmd_ready === rdy_e) else begin
      failures++;
      $error("FAIL %s.cmd_ready observed=%0b expected=%0b", tag, cmd_ready, rdy_e);
    end
  endtask

  // Offer one command for exactly one accepting edge.
  task automatic send(input logic [1:0] dir, input logic [1:0] tq);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_torque = tq;
    tick(1);
    cmd_valid  = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cmd_valid  = 1'b0;
    cmd_dir    = 2'd0;
    cmd_torque = 2'd0;
    estop      = 1'b0;
    reset      = 1'b0;
    #1 reset = 1'b1;
    #2;
    expect_outs("reset", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #3 reset = 1'b0;
    tick(1);

    // Ramp FWD 0 -> 3, one level every 4 cycles.
    send(2'd0, 2'd3);
    expect_outs("up_accept", 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
    tick(3);
    expect_outs("up_c3", 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
    tick(1);
    expect_outs("up_c4", 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    tick(4);
    expect_outs("up_c8", 1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
    tick(4);
    expect_outs("up_c12", 1'b1, 2'd0, 2'd3, 1'b0, 1'b1);

    // Direction change FWD 3 -> REV 2 through zero.
    send(2'd1, 2'd2);
    expect_outs("sw_accept", 1'b1, 2'd0, 2'd3, 1'b1, 1'b0);
    tick(4);
    expect_outs("sw_p4", 1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
    tick(4);
    expect_outs("sw_p8", 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    tick(4);
    expect_outs("sw_p12", 1'b1, 2'd1, 2'd0, 1'b1, 1'b0);
    tick(4);
    expect_outs("sw_p16", 1'b1, 2'd1, 2'd1, 1'b1, 1'b0);
    tick(4);
    expect_outs("sw_p20", 1'b1, 2'd1, 2'd2, 1'b0, 1'b1);

    // Same-direction ramp down to zero ends in IDLE.
    send(2'd1, 2'd0);
    expect_outs("dn_accept", 1'b1, 2'd1, 2'd2, 1'b1, 1'b0);
    tick(4);
    expect_outs("dn_p4", 1'b1, 2'd1, 2'd1, 1'b1, 1'b0);
    tick(4);
    expect_outs("dn_p8", 1'b0, 2'd1, 2'd0, 1'b0, 1'b1);

    // Zero-torque command in IDLE only changes instruction.
    send(2'd2, 2'd0);
    expect_outs("idle_zero", 1'b0, 2'd2, 2'd0, 1'b0, 1'b1);

    // estop mid ramp-up with a competing command.
    send(2'd0, 2'd3);
    tick(4);
    expect_outs("es_pre", 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    estop      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_dir    = 2'd3;
    cmd_torque = 2'd2;
    #1;
    expect_outs("es_comb", 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    tick(1);
    expect_outs("es_edge", 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    tick(4);
    expect_outs("es_held", 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    estop     = 1'b0;
    #1;
    expect_outs("es_release", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    tick(1);

    // Asynchronous reset between edges, just before a pending step.
    send(2'd3, 2'd3);
    tick(4);
    expect_outs("ar_pre", 1'b1, 2'd3, 2'd1, 1'b1, 1'b0);
    tick(3);
    #2 reset = 1'b1;
    #1;
    expect_outs("ar_async", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    tick(1);
    expect_outs("ar_after", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);

    // Equal-torque command in HOLD is a no-op.
    send(2'd0, 2'd2);
    tick(8);
    expect_outs("eq_hold", 1'b1, 2'd0, 2'd2, 1'b0, 1'b1);
    send(2'd0, 2'd2);
    expect_outs("eq_accept", 1'b1, 2'd0, 2'd2, 1'b0, 1'b1);
    tick(5);
    expect_outs("eq_later", 1'b1, 2'd0, 2'd2, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
